// File: rtl/seg7_scan_driver_if.sv
// seg7_scan_driver_if: BCD digit inputs and multiplexed display outputs of the scan driver
interface seg7_scan_driver_if;
  logic [3:0] sec_units;
  logic [3:0] sec_tens;
  logic [3:0] min_units;
  logic [3:0] min_tens;
  logic blank_lz;
  logic blink_en;
  logic [3:0] an_n;
  logic [6:0] seg_n;
  logic dp_n;
  logic frame_done;
  modport master (
    output sec_units, sec_tens, min_units, min_tens, blank_lz, blink_en,
    input an_n, seg_n, dp_n, frame_done
  );
  modport slave (
    input sec_units, sec_tens, min_units, min_tens, blank_lz, blink_en,
    output an_n, seg_n, dp_n, frame_done
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: 4-digit multiplexed 7-segment driver with frame snapshot, guard, blanking and blink
module seg7_scan_driver #(
  parameter int SCAN_DIV = 50000,
  parameter int GUARD = 16,
  parameter int BLINK_FRAMES = 125
) (
  input logic clock,
  input logic reset_n,
  seg7_scan_driver_if.slave bus
);
  localparam int SW = $clog2(SCAN_DIV);
  localparam int BW = $clog2(BLINK_FRAMES + 1);
  localparam logic [SW-1:0] LAST = SW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] GD = SW'(GUARD);
  localparam logic [BW-1:0] BLAST = BW'(BLINK_FRAMES - 1);
  localparam logic [6:0] SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F
  };
  logic [SW-1:0] slot_cnt;
  logic [1:0] digit_idx;
  logic [3:0] snap [4];
  logic snap_lz;
  logic [BW-1:0] blink_cnt;
  logic blink_phase;
  logic slot_end;
  logic load;
  logic lit;
  logic [3:0] cur;
  always_comb begin
    slot_end = slot_cnt == LAST;
    load = slot_end && digit_idx == 2'd3;
    cur = snap[digit_idx];
    lit = slot_cnt >= GD && !blink_phase && !(digit_idx == 2'd3 && snap_lz && snap[3] == 4'd0);
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      slot_cnt <= '0;
      digit_idx <= 2'd0;
      snap <= '{default: 4'h0};
      snap_lz <= 1'b0;
      blink_cnt <= '0;
      blink_phase <= 1'b0;
    end else begin
      slot_cnt <= slot_end ? '0 : slot_cnt + 1'b1;
      digit_idx <= slot_end ? digit_idx + 2'd1 : digit_idx;
      if (load) begin
        snap <= '{bus.sec_units, bus.sec_tens, bus.min_units, bus.min_tens};
        snap_lz <= bus.blank_lz;
      end
      if (!bus.blink_en) begin
        blink_cnt <= '0;
        blink_phase <= 1'b0;
      end else if (load) begin
        blink_cnt <= blink_cnt == BLAST ? '0 : blink_cnt + 1'b1;
        blink_phase <= blink_cnt == BLAST ? !blink_phase : blink_phase;
      end
    end
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bus.an_n <= 4'hF;
      bus.seg_n <= 7'h7F;
      bus.dp_n <= 1'b1;
      bus.frame_done <= 1'b0;
    end else begin
      bus.an_n <= lit ? ~(4'b0001 << digit_idx) : 4'hF;
      bus.seg_n <= SEG[cur];
      bus.dp_n <= !(lit && digit_idx == 2'd2);
      bus.frame_done <= load;
    end
  end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: scoreboard bench for seg7_scan_driver against a frame-level reference model
module tb_seg7_scan_driver;
  localparam int S = 8;
  localparam int G = 2;
  localparam int BF = 2;
  localparam int FR = 4 * S;
  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic dp;
    logic fd;
  } exp_t;
  logic clock;
  logic reset_n;
  int checks = 0;
  int failures = 0;
  exp_t q[$];
  int e;
  logic [3:0] shown [4];
  bit shown_lz;
  int bnd;
  seg7_scan_driver_if bus ();
  seg7_scan_driver #(.SCAN_DIV(S), .GUARD(G), .BLINK_FRAMES(BF)) dut (
    .clock(clock),
    .reset_n(reset_n),
    .bus(bus)
  );
  initial clock = 1'b0;
  always #5 clock = ~clock;
  function automatic logic [6:0] dec(input logic [3:0] v);
    case (v)
      4'd0: return 7'h40;
      4'd1: return 7'h79;
      4'd2: return 7'h24;
      4'd3: return 7'h30;
      4'd4: return 7'h19;
      4'd5: return 7'h12;
      4'd6: return 7'h02;
      4'd7: return 7'h78;
      4'd8: return 7'h00;
      4'd9: return 7'h10;
      default: return 7'h3F;
    endcase
  endfunction
  task automatic tick();
    exp_t x;
    int p, d, s;
    bit lit, off;
    if (!reset_n) begin
      x = '{an: 4'hF, seg: 7'h7F, dp: 1'b1, fd: 1'b0};
      e = 0;
      shown = '{default: 4'h0};
      shown_lz = 0;
      bnd = 0;
    end else begin
      p = e % FR;
      d = p / S;
      s = p % S;
      off = ((bnd / BF) % 2) == 1;
      lit = s >= G && !off && !(d == 3 && shown_lz && shown[3] == 4'd0);
      x.an = lit ? 4'hF & ~(4'b0001 << d) : 4'hF;
      x.seg = dec(shown[d]);
      x.dp = !(lit && d == 2);
      x.fd = p == FR - 1;
      if (p == FR - 1) begin
        shown = '{bus.sec_units, bus.sec_tens, bus.min_units, bus.min_tens};
        shown_lz = bus.blank_lz;
      end
      bnd = !bus.blink_en ? 0 : bnd + ((p == FR - 1) ? 1 : 0);
      e++;
    end
    q.push_back(x);
    @(negedge clock);
  endtask
  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask
  task automatic set_digits(input logic [3:0] mt, mu, st, su);
    bus.min_tens = mt;
    bus.min_units = mu;
    bus.sec_tens = st;
    bus.sec_units = su;
  endtask
  always begin
    exp_t x, a;
    @(posedge clock);
    #1;
    if (q.size() > 0) begin
      x = q.pop_front();
      a = '{an: bus.an_n, seg: bus.seg_n, dp: bus.dp_n, fd: bus.frame_done};
      checks++;
      if (a !== x) begin
        failures++;
        $display("FAIL outputs t=%0t an_n=%h seg_n=%h dp_n=%b frame_done=%b required an_n=%h seg_n=%h dp_n=%b frame_done=%b",
          $time, a.an, a.seg, a.dp, a.fd, x.an, x.seg, x.dp, x.fd);
      end
    end
  end
  always @(negedge reset_n) begin
    #1;
    checks++;
    if (bus.an_n !== 4'hF || bus.seg_n !== 7'h7F || bus.dp_n !== 1'b1 || bus.frame_done !== 1'b0) begin
      failures++;
      $display("FAIL async_reset t=%0t an_n=%h seg_n=%h dp_n=%b frame_done=%b required F 7F 1 0",
        $time, bus.an_n, bus.seg_n, bus.dp_n, bus.frame_done);
    end
  end
  initial begin
    reset_n = 1'b0;
    set_digits(4'd1, 4'd2, 4'd3, 4'd4);
    bus.blank_lz = 1'b0;
    bus.blink_en = 1'b0;
    run(3);
    reset_n = 1'b1;
    run(36);
    bus.sec_units = 4'd7;
    run(FR * 2 - 36 + 4);
    bus.blank_lz = 1'b1;
    bus.min_tens = 4'd0;
    run(FR * 2);
    bus.blank_lz = 1'b0;
    bus.min_tens = 4'd10;
    run(FR * 2);
    reset_n = 1'b0;
    bus.blink_en = 1'b1;
    set_digits(4'd0, 4'd5, 4'd0, 4'd9);
    run(2);
    reset_n = 1'b1;
    run(FR * 6);
    run(FR * 2 + 11);
    bus.blink_en = 1'b0;
    run(FR + 4);
    reset_n = 1'b0;
    run(2);
    reset_n = 1'b1;
    set_digits(4'd1, 4'd2, 4'd3, 4'd4);
    run(13);
    reset_n = 1'b0;
    run(2);
    reset_n = 1'b1;
    run(FR * 2 + 2);
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        case ($urandom_range(0, 4))
          0: bus.sec_units = 4'($urandom_range(0, 4) == 0 ? $urandom_range(10, 15) : $urandom_range(0, 9));
          1: bus.sec_tens = 4'($urandom_range(0, 5));
          2: bus.min_units = 4'($urandom_range(0, 9));
          3: bus.min_tens = 4'($urandom_range(0, 2) == 0 ? 0 : $urandom_range(0, 15));
          default: bus.blank_lz = 1'($urandom_range(0, 1));
        endcase
      end
      if ($urandom_range(0, 299) == 0) bus.blink_en = !bus.blink_en;
      reset_n = $urandom_range(0, 799) != 0;
      tick();
    end
    reset_n = 1'b1;
    run(2);
    @(posedge clock);
    #2;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain pending=%0d required 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
